// File: rtl/dbg_cmd_engine.sv
// Host debug command engine: parses 2-byte (cmd, data) packets from the RX FIFO, drives the CPU
// reset/phase/data ports and answers with a framed status packet through the TX FIFO.
module dbg_cmd_engine #(
    parameter int unsigned STATUS_BYTES = 12,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CYC  = 1000000,
    parameter int unsigned PHASE_DIV    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_empty,
    output logic                      rx_rd,
    input  logic [7:0]                rx_data,
    input  logic                      tx_full,
    output logic                      tx_wr,
    output logic [7:0]                tx_data,
    output logic                      cpu_rst,
    output logic                      clk_ph1,
    output logic                      clk_ph2,
    output logic [7:0]                cpu_din,
    input  logic [STATUS_BYTES*8-1:0] status_in,
    output logic                      busy,
    output logic                      err_timeout
);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned DIV_W = $clog2(PHASE_DIV);
    localparam int unsigned IDX_W = $clog2(STATUS_BYTES + 1);

    localparam logic [3:0] StIdle     = 4'd0;
    localparam logic [3:0] StRdCmd    = 4'd1;
    localparam logic [3:0] StWaitData = 4'd2;
    localparam logic [3:0] StRdData   = 4'd3;
    localparam logic [3:0] StExec     = 4'd4;
    localparam logic [3:0] StRun      = 4'd5;
    localparam logic [3:0] StTxSync   = 4'd6;
    localparam logic [3:0] StTxBody   = 4'd7;
    localparam logic [3:0] StTxSum    = 4'd8;

    logic [3:0]       state_q, state_d;
    logic [7:0]       cmd_q, cmd_d, data_q, data_d, din_q, din_d;
    logic             phase_q, phase_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       rem_q, rem_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cpu_rst_q, cpu_rst_d, ph1_q, ph1_d, ph2_q, ph2_d, err_q, err_d;
    logic             rd_req, wr_req, load_body;
    logic [7:0]       tx_byte, pbyte, csum;

    // Frame body: index 0 is the phase byte, 1..STATUS_BYTES the captured CPU state
    logic [7:0]       body_q [STATUS_BYTES+1];

    always_comb begin
        if (cmd_q == 8'h00) begin
            pbyte = 8'h00;
        end else if (cmd_q <= 8'h03) begin
            pbyte = {7'd0, ~phase_d} + 8'd1;
        end else begin
            pbyte = 8'hFF;
        end
    end

    always_comb begin
        csum = 8'h00;
        for (int i = 0; i <= STATUS_BYTES; i++) begin
            csum = csum ^ body_q[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        phase_d   = phase_q;
        din_d     = din_q;
        to_cnt_d  = to_cnt_q;
        div_d     = div_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        cpu_rst_d = 1'b0;
        ph1_d     = 1'b0;
        ph2_d     = 1'b0;
        err_d     = 1'b0;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        tx_byte   = 8'h00;
        case (state_q)
            StIdle: begin
                if (!rx_empty) begin
                    rd_req   = 1'b1;
                    to_cnt_d = '0;
                    state_d  = StRdCmd;
                end
            end
            StRdCmd: begin
                cmd_d    = rx_data;
                to_cnt_d = to_cnt_q + 1'b1;
                state_d  = StWaitData;
            end
            StWaitData: begin
                // A data byte arriving in the expiry cycle still wins
                if (!rx_empty) begin
                    rd_req  = 1'b1;
                    state_d = StRdData;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StRdData: begin
                data_d  = rx_data;
                state_d = StExec;
            end
            StExec: begin
                state_d = StTxSync;
                case (cmd_q)
                    8'h00: begin
                        cpu_rst_d = 1'b1;
                        phase_d   = 1'b0;
                        din_d     = 8'h00;
                    end
                    8'h01: begin
                        din_d   = data_q;
                        ph1_d   = ~phase_q;
                        ph2_d   = phase_q;
                        phase_d = ~phase_q;
                    end
                    8'h02: begin
                        // First pulse issued here; rem counts the pulses still to come
                        din_d   = data_q;
                        ph1_d   = ~phase_q;
                        ph2_d   = phase_q;
                        phase_d = ~phase_q;
                        rem_d   = (data_q == 8'h00) ? 10'd511 : {1'b0, data_q, 1'b0} - 10'd1;
                        div_d   = DIV_W'(PHASE_DIV - 1);
                        state_d = StRun;
                    end
                    default: ;
                endcase
            end
            StRun: begin
                if (rem_q == '0) begin
                    state_d = StTxSync;
                end else if (div_q == '0) begin
                    ph1_d   = ~phase_q;
                    ph2_d   = phase_q;
                    phase_d = ~phase_q;
                    div_d   = DIV_W'(PHASE_DIV - 1);
                    rem_d   = rem_q - 1'b1;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            StTxSync: begin
                tx_byte = SYNC_BYTE;
                if (!tx_full) begin
                    wr_req  = 1'b1;
                    idx_d   = '0;
                    state_d = StTxBody;
                end
            end
            StTxBody: begin
                tx_byte = body_q[idx_q];
                if (!tx_full) begin
                    wr_req = 1'b1;
                    if (idx_q == IDX_W'(STATUS_BYTES)) begin
                        state_d = StTxSum;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StTxSum: begin
                tx_byte = csum;
                if (!tx_full) begin
                    wr_req  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign load_body = (state_d == StTxSync) && (state_q != StTxSync);

    always_ff @(posedge clk) begin
        if (load_body) begin
            body_q[0] <= pbyte;
            for (int i = 0; i < STATUS_BYTES; i++) begin
                body_q[i+1] <= status_in[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cmd_q     <= 8'h00;
            data_q    <= 8'h00;
            phase_q   <= 1'b0;
            din_q     <= 8'h00;
            to_cnt_q  <= '0;
            div_q     <= '0;
            rem_q     <= '0;
            idx_q     <= '0;
            cpu_rst_q <= 1'b1;
            ph1_q     <= 1'b0;
            ph2_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            phase_q   <= phase_d;
            din_q     <= din_d;
            to_cnt_q  <= to_cnt_d;
            div_q     <= div_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            cpu_rst_q <= cpu_rst_d;
            ph1_q     <= ph1_d;
            ph2_q     <= ph2_d;
            err_q     <= err_d;
        end
    end

    // FIFO strobes are combinational so rx_data lines up with RD_CMD/RD_DATA
    assign rx_rd       = rd_req & ~rst;
    assign tx_wr       = wr_req & ~rst;
    assign tx_data     = rst ? 8'h00 : tx_byte;
    assign busy        = (state_q != StIdle);
    assign cpu_rst     = cpu_rst_q;
    assign clk_ph1     = ph1_q;
    assign clk_ph2     = ph2_q;
    assign cpu_din     = din_q;
    assign err_timeout = err_q;

endmodule
